stopwatch_ctrl: RTL and testbench

Run/pause/clear controller and BCD mm:ss counter for the stopwatch display path. Sequences a four-digit BCD count (minutes tens/ones, seconds tens/ones) from a 1 Hz enable pulse and single-cycle button pulses. Raises a sticky alarm flag when the count reaches a programmable target time. Drives the digit bus consumed by the display decoder and the alarm/LED logic.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/stopwatch_ctrl_bcd_digit_cnt.sv | 31 +++
 rtl/stopwatch_ctrl.sv | 122 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types, digit limits and the BCD step helper for the stopwatch path.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam int ONES_MAX = 9;
   localparam int TENS_MAX = 5;

   // Value a digit takes after the coming edge: hold, wrap at the limit, or +1.
   function automatic logic [3:0] bcd_next(input logic [3:0] q,
                                           input logic       en,
                                           input logic [3:0] max_v);
      logic [3:0] nxt;
      nxt = q;
      if (en) begin
         if (q == max_v) nxt = 4'd0;
         else            nxt = q + 4'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit_cnt.sv
// Single BCD digit counter: counts 0..MAX on en, wraps to 0 and flags carry.
module bcd_digit_cnt #(
   parameter int MAX = 9,
   parameter int W   = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] q,
   output logic         carry
);

   localparam logic [W-1:0] L_MAX = W'(MAX);

   logic [W-1:0] r_q;

   // Digit register: clear wins over increment; wrap to zero past MAX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             r_q <= '0;
      else if (clr)        r_q <= '0;
      else if (en) begin
         if (r_q == L_MAX) r_q <= '0;
         else              r_q <= r_q + W'(1);
      end
   end

   assign q     = r_q;
   assign carry = en && (r_q == L_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller with a four-digit BCD mm:ss count and a sticky
// alarm that rises when the count lands on the target time.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int ALM_M1 = 5,
   parameter int ALM_M0 = 9,
   parameter int ALM_S1 = 5,
   parameter int ALM_S0 = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start_stop,
   input  logic       clear,
   output logic [3:0] nums_0_s,
   output logic [2:0] nums_1_s,
   output logic [3:0] nums_0_m,
   output logic [2:0] nums_1_m,
   output logic       running,
   output logic       alarm,
   output logic [1:0] dbg_state
);

   localparam logic [3:0] L_ONES = 4'(ONES_MAX);
   localparam logic [3:0] L_TENS = 4'(TENS_MAX);
   localparam logic [3:0] L_M1   = 4'(ALM_M1);
   localparam logic [3:0] L_M0   = 4'(ALM_M0);
   localparam logic [3:0] L_S1   = 4'(ALM_S1);
   localparam logic [3:0] L_S0   = 4'(ALM_S0);

   state_t     r_state;
   state_t     w_state_nxt;
   logic       w_inc;
   logic       r_running;
   logic       r_alarm;

   logic [3:0] w_s0;
   logic [2:0] w_s1;
   logic [3:0] w_m0;
   logic [2:0] w_m1;
   logic       w_c_s0, w_c_s1, w_c_m0, w_c_m1;

   logic [3:0] w_nx_s0, w_nx_s1, w_nx_m0, w_nx_m1;
   logic       w_nx_zero, w_nx_hit;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state (clear > start_stop) and the tick enable, gated by the current state only.
   always_comb begin
      w_state_nxt = r_state;
      w_inc       = 1'b0;
      if (r_state == ST_RUN && tick && !clear) w_inc = 1'b1;
      if (clear) begin
         w_state_nxt = ST_IDLE;
      end else if (start_stop) begin
         case (r_state)
            ST_IDLE:  w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_PAUSE;
            ST_PAUSE: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Registered running flag tracks the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_running <= 1'b0;
      else     r_running <= (w_state_nxt == ST_RUN);
   end

   bcd_digit_cnt #(.MAX(ONES_MAX), .W(4)) u_s0 (
      .clk(clk), .rst(rst), .en(w_inc),  .clr(clear), .q(w_s0), .carry(w_c_s0));
   bcd_digit_cnt #(.MAX(TENS_MAX), .W(3)) u_s1 (
      .clk(clk), .rst(rst), .en(w_c_s0), .clr(clear), .q(w_s1), .carry(w_c_s1));
   bcd_digit_cnt #(.MAX(ONES_MAX), .W(4)) u_m0 (
      .clk(clk), .rst(rst), .en(w_c_s1), .clr(clear), .q(w_m0), .carry(w_c_m0));
   bcd_digit_cnt #(.MAX(TENS_MAX), .W(3)) u_m1 (
      .clk(clk), .rst(rst), .en(w_c_m0), .clr(clear), .q(w_m1), .carry(w_c_m1));

   // Count the digits will hold after this edge, so alarm lines up with the display.
   always_comb begin
      w_nx_s0 = 4'd0;
      w_nx_s1 = 4'd0;
      w_nx_m0 = 4'd0;
      w_nx_m1 = 4'd0;
      if (!clear) begin
         w_nx_s0 = bcd_next(w_s0,         w_inc,  L_ONES);
         w_nx_s1 = bcd_next({1'b0, w_s1}, w_c_s0, L_TENS);
         w_nx_m0 = bcd_next(w_m0,         w_c_s1, L_ONES);
         w_nx_m1 = bcd_next({1'b0, w_m1}, w_c_m0, L_TENS);
      end
      w_nx_zero = (w_nx_s0 == 4'd0) && (w_nx_s1 == 4'd0) &&
                  (w_nx_m0 == 4'd0) && (w_nx_m1 == 4'd0);
      w_nx_hit  = (w_nx_s0 == L_S0) && (w_nx_s1 == L_S1) &&
                  (w_nx_m0 == L_M0) && (w_nx_m1 == L_M1);
   end

   // Sticky alarm: drops when the count returns to 00:00, rises on the target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_alarm <= 1'b0;
      else if (w_nx_zero) r_alarm <= 1'b0;
      else if (w_nx_hit)  r_alarm <= 1'b1;
   end

   assign nums_0_s  = w_s0;
   assign nums_1_s  = w_s1;
   assign nums_0_m  = w_m0;
   assign nums_1_m  = w_m1;
   assign running   = r_running;
   assign alarm     = r_alarm;
   assign dbg_state = r_state;

   // The top-digit carry marks the 59:59 -> 00:00 wrap; nothing downstream uses it.
   logic w_unused;
   assign w_unused = w_c_m1;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: reset, run/pause, alarm and wrap,
// same-cycle priority cases and a full-hour sweep.
module tb_stopwatch_ctrl;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic        start_stop = 1'b0;
   logic        clear = 1'b0;
   logic [3:0]  nums_0_s;
   logic [2:0]  nums_1_s;
   logic [3:0]  nums_0_m;
   logic [2:0]  nums_1_m;
   logic        running;
   logic        alarm;
   logic [1:0]  dbg_state;
   logic [13:0] disp;

   int n_cmp = 0;
   int n_err = 0;

   stopwatch_ctrl dut (
      .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
      .nums_0_s(nums_0_s), .nums_1_s(nums_1_s), .nums_0_m(nums_0_m), .nums_1_m(nums_1_m),
      .running(running), .alarm(alarm), .dbg_state(dbg_state));

   assign disp = {nums_1_m, nums_0_m, nums_1_s, nums_0_s};

   // Clock.
   always #5 clk = ~clk;

   function automatic logic [13:0] bcd(input int m, input int s);
      return {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
   endfunction

   // One clock with the given pulses; outputs are stable 1 time unit after the edge.
   task automatic step(input logic ss, input logic tk, input logic cl);
      start_stop = ss;
      tick       = tk;
      clear      = cl;
      @(posedge clk);
      #1;
      start_stop = 1'b0;
      tick       = 1'b0;
      clear      = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      n_cmp++; if (disp !== 14'd0) begin n_err++; $display("FAIL rst_digits got=%h exp=%h", disp, 14'd0); end
      n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL rst_running got=%b exp=0", running); end
      n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL rst_alarm got=%b exp=0", alarm); end
      rst = 1'b0;
      step(1'b0, 1'b1, 1'b0);
      n_cmp++; if (disp !== 14'd0 || dbg_state !== S_IDLE) begin n_err++; $display("FAIL idle_tick_ignored got=%h/%0d exp=0/%0d", disp, dbg_state, S_IDLE); end
      step(1'b1, 1'b0, 1'b0);
      ticks(754);
      n_cmp++; if (disp !== bcd(12, 34)) begin n_err++; $display("FAIL run_12_34 got=%h exp=%h", disp, bcd(12, 34)); end
      n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL run_running got=%b exp=1", running); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (disp !== 14'd0) begin n_err++; $display("FAIL async_rst_digits got=%h exp=0", disp); end
      n_cmp++; if (running !== 1'b0 || alarm !== 1'b0) begin n_err++; $display("FAIL async_rst_flags got=%b%b exp=00", running, alarm); end
      #1 rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (dbg_state !== S_IDLE || disp !== 14'd0) begin n_err++; $display("FAIL post_rst_idle got=%0d/%h exp=%0d/0", dbg_state, disp, S_IDLE); end
   endtask

   task automatic test_run_pause();
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 75; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (i % 5 == 4) step(1'b0, 1'b0, 1'b0);
      end
      n_cmp++; if (disp !== bcd(1, 15)) begin n_err++; $display("FAIL run_01_15 got=%h exp=%h", disp, bcd(1, 15)); end
      n_cmp++; if (running !== 1'b1 || dbg_state !== S_RUN) begin n_err++; $display("FAIL run_state got=%b/%0d exp=1/%0d", running, dbg_state, S_RUN); end
      step(1'b1, 1'b0, 1'b0);
      ticks(3);
      n_cmp++; if (disp !== bcd(1, 15)) begin n_err++; $display("FAIL pause_hold got=%h exp=%h", disp, bcd(1, 15)); end
      n_cmp++; if (running !== 1'b0 || dbg_state !== S_PAUSE) begin n_err++; $display("FAIL pause_state got=%b/%0d exp=0/%0d", running, dbg_state, S_PAUSE); end
      n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL pause_alarm got=%b exp=0", alarm); end
   endtask

   task automatic test_alarm_wrap();
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      ticks(3592);
      n_cmp++; if (disp !== bcd(59, 52) || alarm !== 1'b0) begin n_err++; $display("FAIL pre_target got=%h/%b exp=%h/0", disp, alarm, bcd(59, 52)); end
      ticks(1);
      n_cmp++; if (disp !== bcd(59, 53) || alarm !== 1'b1) begin n_err++; $display("FAIL target_hit got=%h/%b exp=%h/1", disp, alarm, bcd(59, 53)); end
      step(1'b1, 1'b0, 1'b0);
      ticks(2);
      n_cmp++; if (disp !== bcd(59, 53) || alarm !== 1'b1) begin n_err++; $display("FAIL alarm_in_pause got=%h/%b exp=%h/1", disp, alarm, bcd(59, 53)); end
      step(1'b1, 1'b0, 1'b0);
      ticks(6);
      n_cmp++; if (disp !== bcd(59, 59) || alarm !== 1'b1) begin n_err++; $display("FAIL alarm_sticky got=%h/%b exp=%h/1", disp, alarm, bcd(59, 59)); end
      ticks(1);
      n_cmp++; if (disp !== 14'd0 || alarm !== 1'b0) begin n_err++; $display("FAIL wrap_clears got=%h/%b exp=0/0", disp, alarm); end
      n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL wrap_keeps_run got=%b exp=1", running); end
   endtask

   task automatic test_back_to_back();
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      ticks(9);
      n_cmp++; if (disp !== bcd(0, 9)) begin n_err++; $display("FAIL b2b_00_09 got=%h exp=%h", disp, bcd(0, 9)); end
      step(1'b1, 1'b1, 1'b0);
      n_cmp++; if (disp !== bcd(0, 10) || dbg_state !== S_PAUSE || running !== 1'b0) begin n_err++; $display("FAIL ss_tick_in_run got=%h/%0d/%b exp=%h/%0d/0", disp, dbg_state, running, bcd(0, 10), S_PAUSE); end
      step(1'b1, 1'b1, 1'b0);
      n_cmp++; if (disp !== bcd(0, 10) || dbg_state !== S_RUN || running !== 1'b1) begin n_err++; $display("FAIL ss_tick_in_pause got=%h/%0d/%b exp=%h/%0d/1", disp, dbg_state, running, bcd(0, 10), S_RUN); end
   endtask

   task automatic test_clear_priority();
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      ticks(3595);
      n_cmp++; if (disp !== bcd(59, 55) || alarm !== 1'b1) begin n_err++; $display("FAIL pre_clear got=%h/%b exp=%h/1", disp, alarm, bcd(59, 55)); end
      step(1'b1, 1'b1, 1'b1);
      n_cmp++; if (disp !== 14'd0 || dbg_state !== S_IDLE) begin n_err++; $display("FAIL clear_wins got=%h/%0d exp=0/%0d", disp, dbg_state, S_IDLE); end
      n_cmp++; if (alarm !== 1'b0 || running !== 1'b0) begin n_err++; $display("FAIL clear_flags got=%b%b exp=00", alarm, running); end
   endtask

   task automatic test_sweep();
      int   rises;
      logic prev;
      int   t_mod;
      rises = 0;
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      prev = alarm;
      for (int t = 1; t <= 3600; t++) begin
         step(1'b0, 1'b1, 1'b0);
         t_mod = t % 3600;
         n_cmp++;
         if (disp !== bcd(t_mod / 60, t_mod % 60)) begin
            n_err++;
            $display("FAIL sweep_digits t=%0d got=%h exp=%h", t, disp, bcd(t_mod / 60, t_mod % 60));
         end
         n_cmp++;
         if (alarm !== (t_mod >= 3593)) begin
            n_err++;
            $display("FAIL sweep_alarm t=%0d got=%b exp=%b", t, alarm, (t_mod >= 3593));
         end
         if (alarm && !prev) rises++;
         prev = alarm;
      end
      n_cmp++; if (rises !== 1) begin n_err++; $display("FAIL sweep_rises got=%0d exp=1", rises); end
   endtask

   initial begin
      test_reset();
      test_run_pause();
      test_alarm_wrap();
      test_back_to_back();
      test_clear_priority();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
